// File: rtl/msdft_bin_ctrl.sv
// Sequencer for one MSDFT bin: owns the datapath length and reset, gates input valids
// and hides outputs from partly filled windows. Optional framing via MSDFT_BIN_CTRL_FRAME_EN.
module msdft_bin_ctrl #(
  parameter int DFT_LEN    = 128,
  parameter int PIPE_LAT   = 8,
  parameter int RST_CYCLES = 2,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cfg_len,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic                  din_valid,
  output logic                  dp_din_valid,
  output logic                  dp_rst,
  output logic [31:0]           dp_delay_line,
  input  logic                  dp_dout_valid,
  output logic                  dout_valid,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_cnt
`ifdef MSDFT_BIN_CTRL_FRAME_EN
  ,
  output logic                  frame_tick,
  output logic [31:0]           frame_cnt
`endif
);

  localparam int FILL_W  = (DFT_LEN > 2) ? $clog2(DFT_LEN) : 1;
  localparam int SEQ_MAX = (PIPE_LAT > RST_CYCLES) ? PIPE_LAT : RST_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(PIPE_LAT - 1);
  localparam logic [SEQ_W-1:0] RST_LAST   = SEQ_W'(RST_CYCLES - 1);
  localparam logic [31:0]      LEN_MAX    = 32'(DFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_DRAIN,
    ST_RESET,
    ST_FILL,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [SEQ_W-1:0]        seq_cnt_q, seq_cnt_d;
  logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [31:0]             pend_len_q, pend_len_d;
  logic [31:0]             dl_q, dl_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [DROP_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    dp_rst_q;
  logic                    cfg_ready_q;
  logic                    busy_q;

  logic cfg_accept;
  logic len_ok;
  logic cfg_go;
  logic fill_last;
  logic dropping;

  assign cfg_accept = cfg_valid & cfg_ready_q;
  assign len_ok     = (cfg_len != 32'd0) && (cfg_len <= LEN_MAX);
  assign cfg_go     = cfg_accept & len_ok;
  assign fill_last  = (32'(fill_cnt_q) == dl_q);
  assign dropping   = din_valid && ((state_q == ST_DRAIN) || (state_q == ST_RESET));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    seq_cnt_d    = seq_cnt_q;
    fill_cnt_d   = fill_cnt_q;
    pend_len_d   = pend_len_q;
    dl_d         = dl_q;
    cfg_err_d    = cfg_err_q;
    drop_cnt_d   = drop_cnt_q;
    dp_din_valid = 1'b0;
    dout_valid   = 1'b0;

    case (state_q)
      ST_DRAIN: begin
        if (seq_cnt_q == DRAIN_LAST) begin
          state_d   = ST_RESET;
          seq_cnt_d = '0;
          dl_d      = pend_len_q;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      ST_RESET: begin
        if (seq_cnt_q == RST_LAST) begin
          state_d    = ST_FILL;
          seq_cnt_d  = '0;
          fill_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      ST_FILL: begin
        dp_din_valid = din_valid;
        // A new length abandons the fill, including a window completing this cycle.
        if (cfg_go) begin
          state_d   = ST_DRAIN;
          seq_cnt_d = '0;
        end else if (dp_dout_valid) begin
          if (fill_last) begin
            dout_valid = 1'b1;
            state_d    = ST_RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        dp_din_valid = din_valid;
        dout_valid   = dp_dout_valid;
        if (cfg_go) begin
          state_d   = ST_DRAIN;
          seq_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_RESET;
        seq_cnt_d = '0;
      end
    endcase

    if (cfg_accept) begin
      cfg_err_d = ~len_ok;
      if (len_ok) pend_len_d = cfg_len;
    end

    if (dropping && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample
  // the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      seq_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      pend_len_q  <= LEN_MAX;
      dl_q        <= LEN_MAX;
      cfg_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
      dp_rst_q    <= 1'b1;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      pend_len_q  <= pend_len_d;
      dl_q        <= dl_d;
      cfg_err_q   <= cfg_err_d;
      drop_cnt_q  <= drop_cnt_d;
      dp_rst_q    <= (state_d == ST_RESET);
      cfg_ready_q <= (state_d == ST_FILL) || (state_d == ST_RUN);
      busy_q      <= (state_d != ST_RUN);
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign cfg_err       = cfg_err_q;
  assign dp_rst        = dp_rst_q;
  assign dp_delay_line = dl_q;
  assign busy          = busy_q;
  assign drop_cnt      = drop_cnt_q;

`ifdef MSDFT_BIN_CTRL_FRAME_EN
  logic [FILL_W-1:0] frame_mod_q, frame_mod_d;
  logic [31:0]       frame_cnt_q;

  // The fill-completing output is window #1, so the modulo count starts at zero there.
  always_comb begin
    frame_mod_d = frame_mod_q;
    frame_tick  = dout_valid && (frame_mod_q == '0);
    if ((state_q == ST_DRAIN) || (state_q == ST_RESET)) begin
      frame_mod_d = '0;
    end else if (dout_valid) begin
      frame_mod_d = (32'(frame_mod_q) == dl_q) ? '0 : frame_mod_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_mod_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      frame_mod_q <= frame_mod_d;
      if (frame_tick) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
